// File: rtl/bytebeat_sequencer.sv
// Sample-rate scheduler for the bytebeat evaluator: divides clk into sample ticks,
// keeps the time counter t, launches one evaluation per tick and registers the result.
module bytebeat_sequencer #(
  parameter int CLK_DIV      = 1250,
  parameter int T_WIDTH      = 24,
  parameter int EVAL_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [1:0]         cfg_sel,
  input  logic               cfg_pause,
  input  logic               cfg_restart,
  output logic               eval_start,
  output logic [T_WIDTH-1:0] eval_t,
  output logic [1:0]         eval_sel,
  input  logic               eval_done,
  input  logic [7:0]         eval_sample,
  output logic [7:0]         sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic [1:0]         fault
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = $clog2(EVAL_TIMEOUT + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EVAL_TIMEOUT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [T_WIDTH-1:0] t_q;
  logic               restart_pend_q;
  logic               eval_start_q;
  logic               sample_valid_q;
  logic [T_WIDTH-1:0] eval_t_q;
  logic [1:0]         eval_sel_q;
  logic [7:0]         sample_q;
  logic [1:0]         fault_q;

  logic tick, in_wait, launch, done_ok, timeout, finish, overrun;

  assign tick    = ena && (div_q == DIV_LAST);
  assign in_wait = (state_q == ST_WAIT);
  assign launch  = (state_q == ST_IDLE) && tick && !cfg_pause;
  // The launch cycle itself never accepts a completion; everything is frozen while ena=0.
  assign done_ok = ena && in_wait && !eval_start_q && eval_done;
  assign timeout = ena && in_wait && !done_ok && (wait_q == WAIT_LAST);
  assign finish  = done_ok || timeout;
  // A paused design ignores ticks entirely, so a paused tick is not an overrun either.
  assign overrun = in_wait && tick && !cfg_pause;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of process evaluation order.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (launch) state_d = ST_WAIT;
      ST_WAIT: if (finish) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: pulses are masked while disabled so a held register never repeats a strobe.
  always_comb begin
    eval_start   = eval_start_q & ena;
    sample_valid = sample_valid_q & ena;
    busy         = in_wait;
    eval_t       = eval_t_q;
    eval_sel     = eval_sel_q;
    sample_out   = sample_q;
    fault        = fault_q;
  end

  // Divider, time counter and evaluation datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q          <= '0;
      wait_q         <= '0;
      t_q            <= '0;
      restart_pend_q <= 1'b0;
      eval_start_q   <= 1'b0;
      sample_valid_q <= 1'b0;
      eval_t_q       <= '0;
      eval_sel_q     <= 2'b00;
      sample_q       <= 8'h80;
      fault_q        <= 2'b00;
    end else if (ena) begin
      div_q          <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      eval_start_q   <= launch;
      sample_valid_q <= done_ok;

      if (launch) begin
        eval_t_q   <= cfg_restart ? '0 : t_q;
        eval_sel_q <= cfg_sel;
      end

      if (launch)
        wait_q <= '0;
      else if (in_wait && (wait_q != WAIT_LAST))
        wait_q <= wait_q + WAIT_W'(1);

      if (done_ok) sample_q <= eval_sample;

      // Restart during an evaluation is remembered and wins over the increment at its end.
      if (finish)
        t_q <= (restart_pend_q || cfg_restart) ? '0 : t_q + T_WIDTH'(1);
      else if (cfg_restart && !in_wait)
        t_q <= '0;

      restart_pend_q <= in_wait && !finish && (restart_pend_q || cfg_restart);

      fault_q <= (fault_q & ~{2{cfg_restart}}) | {timeout, overrun};
    end
  end

endmodule

// File: tb/tb_bytebeat_sequencer.sv
// Directed bench for bytebeat_sequencer: a vector table for steady-state sampling plus
// hand-written sequences for overrun, timeout, restart, pause, wrap, enable and reset.
module tb_bytebeat_sequencer;

  localparam int CLK_PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst_n, ena, cfg_pause, cfg_restart;
  logic [1:0]  cfg_sel;
  logic        eval_start, eval_done, sample_valid, busy;
  logic [23:0] eval_t;
  logic [1:0]  eval_sel, fault;
  logic [7:0]  eval_sample, sample_out;

  // Small-width instance used to reach the time-counter wrap in a short run.
  logic        rst_w_n, w_pause, w_start, w_done, w_valid, w_busy;
  logic [3:0]  w_eval_t;
  logic [1:0]  w_sel_out, w_fault;
  logic [7:0]  w_sample, w_sample_out;

  int errors = 0;
  int checks = 0;
  int ev_lat = 3;        // 0 = evaluator never answers
  int stray_req = 0;
  int sv_cnt = 0;

  always #(CLK_PERIOD/2) clk = ~clk;

  bytebeat_sequencer #(.CLK_DIV(8), .T_WIDTH(24), .EVAL_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_sel(cfg_sel), .cfg_pause(cfg_pause),
    .cfg_restart(cfg_restart), .eval_start(eval_start), .eval_t(eval_t), .eval_sel(eval_sel),
    .eval_done(eval_done), .eval_sample(eval_sample), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .fault(fault)
  );

  bytebeat_sequencer #(.CLK_DIV(4), .T_WIDTH(4), .EVAL_TIMEOUT(16)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .ena(1'b1), .cfg_sel(2'b00), .cfg_pause(w_pause),
    .cfg_restart(1'b0), .eval_start(w_start), .eval_t(w_eval_t), .eval_sel(w_sel_out),
    .eval_done(w_done), .eval_sample(w_sample), .sample_out(w_sample_out),
    .sample_valid(w_valid), .busy(w_busy), .fault(w_fault)
  );

  // Evaluator model: answers t[7:0]^8'h5A ev_lat cycles after eval_start; can inject a stray done.
  initial begin
    int seen_stray = 0;
    int lat;
    logic [7:0] res;
    eval_done = 1'b0;
    eval_sample = 8'h00;
    forever begin
      @(negedge clk);
      if (stray_req != seen_stray) begin
        seen_stray = stray_req;
        @(posedge clk); #1;
        eval_done = 1'b1; eval_sample = 8'hEE;
        @(posedge clk); #1;
        eval_done = 1'b0;
      end else if (eval_start && ev_lat != 0) begin
        lat = ev_lat;
        res = eval_t[7:0] ^ 8'h5A;
        repeat (lat) @(posedge clk);
        #1;
        eval_done = 1'b1; eval_sample = res;
        @(posedge clk); #1;
        eval_done = 1'b0;
      end
    end
  end

  // Evaluator for the small instance: one-cycle latency.
  initial begin
    w_done = 1'b0;
    w_sample = 8'h00;
    forever begin
      @(negedge clk);
      if (w_start) begin
        @(posedge clk); #1;
        w_done = 1'b1; w_sample = {4'h0, w_eval_t} ^ 8'h5A;
        @(posedge clk); #1;
        w_done = 1'b0;
      end
    end
  end

  always @(posedge clk) if (sample_valid) sv_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // kind 0: eval_start, 1: sample_valid, 2: w_start. Returns at the negedge where it is high.
  task automatic wait_pulse(input int kind, input string name);
    logic hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      case (kind)
        0:       hit = eval_start;
        1:       hit = sample_valid;
        default: hit = w_start;
      endcase
    end
    check({name, " seen"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [23:0] t;
    logic [7:0]  sample;
    logic [1:0]  fault;
  } vec_t;

  initial begin
    vec_t vecs[4];
    realtime t_prev;
    int sv0;

    vecs[0] = '{24'd0, 8'h5A, 2'b00};
    vecs[1] = '{24'd1, 8'h5B, 2'b00};
    vecs[2] = '{24'd2, 8'h58, 2'b00};
    vecs[3] = '{24'd3, 8'h59, 2'b00};

    rst_n = 1'b0; rst_w_n = 1'b0; ena = 1'b1;
    cfg_sel = 2'b00; cfg_pause = 1'b0; cfg_restart = 1'b0; w_pause = 1'b0;
    step(3);

    // Reset values
    check("rst eval_start",   {31'd0, eval_start}, 32'd0);
    check("rst eval_t",       {8'd0, eval_t}, 32'd0);
    check("rst eval_sel",     {30'd0, eval_sel}, 32'd0);
    check("rst sample_out",   {24'd0, sample_out}, 32'h80);
    check("rst sample_valid", {31'd0, sample_valid}, 32'd0);
    check("rst busy",         {31'd0, busy}, 32'd0);
    check("rst fault",        {30'd0, fault}, 32'd0);

    // Steady state: one launch per 8-cycle tick, 3-cycle evaluator
    rst_n = 1'b1;
    sv0 = sv_cnt;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_pulse(0, $sformatf("v%0d start", i));
      check($sformatf("v%0d eval_t", i), {8'd0, eval_t}, {8'd0, vecs[i].t});
      check($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
      if (i > 0)
        check($sformatf("v%0d spacing", i), int'(($time - t_prev) / CLK_PERIOD), 32'd8);
      t_prev = $time;
      wait_pulse(1, $sformatf("v%0d valid", i));
      check($sformatf("v%0d sample", i), {24'd0, sample_out}, {24'd0, vecs[i].sample});
      check($sformatf("v%0d fault", i), {30'd0, fault}, {30'd0, vecs[i].fault});
    end
    step(1);
    check("steady valid count", sv_cnt - sv0, 32'd4);

    // Restart in IDLE, then a 12-cycle evaluator overruns every other tick
    cfg_restart = 1'b1; ev_lat = 12;
    step(1);
    cfg_restart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(0, $sformatf("ovr%0d start", i));
      check($sformatf("ovr%0d eval_t", i), {8'd0, eval_t}, i);
      if (i > 0)
        check($sformatf("ovr%0d spacing", i), int'(($time - t_prev) / CLK_PERIOD), 32'd16);
      t_prev = $time;
    end
    check("ovr fault", {30'd0, fault}, 32'd1);

    // Restart during WAIT at t=5 with a cfg_sel change mid-evaluation
    step(1);
    ev_lat = 3; cfg_sel = 2'd2;
    begin
      logic found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
        wait_pulse(0, "rs find");
        found = (eval_t == 24'd5);
      end
      check("rs reached t=5", {31'd0, found}, 32'd1);
    end
    check("rs eval_sel at launch", {30'd0, eval_sel}, 32'd2);
    step(1);
    cfg_restart = 1'b1; cfg_sel = 2'd1;
    step(1);
    cfg_restart = 1'b0;
    @(negedge clk);
    check("rs eval_sel held", {30'd0, eval_sel}, 32'd2);
    check("rs busy", {31'd0, busy}, 32'd1);
    wait_pulse(1, "rs valid");
    check("rs sample", {24'd0, sample_out}, 32'h5F);
    check("rs fault cleared", {30'd0, fault}, 32'd0);
    wait_pulse(0, "rs next start");
    check("rs next eval_t", {8'd0, eval_t}, 32'd0);
    check("rs next eval_sel", {30'd0, eval_sel}, 32'd1);

    // Timeout with a 10-cycle ena=0 gap: the wait counter freezes with everything else
    step(1);
    ev_lat = 0;
    step(5);
    do_reset();
    sv0 = sv_cnt;
    wait_pulse(0, "to start");
    check("to eval_t", {8'd0, eval_t}, 32'd0);
    step(1);
    cfg_pause = 1'b1; ena = 1'b0;       // cycle E+1
    step(5);
    check("to start masked", {31'd0, eval_start}, 32'd0);
    check("to busy frozen", {31'd0, busy}, 32'd1);
    step(5);
    ena = 1'b1;                         // cycle E+11
    repeat (16) @(negedge clk);         // negedge of E+26
    check("to pre fault", {30'd0, fault}, 32'd0);
    check("to pre busy", {31'd0, busy}, 32'd1);
    @(negedge clk);                     // E+27
    check("to fault", {30'd0, fault}, 32'd2);
    check("to busy", {31'd0, busy}, 32'd0);
    check("to sample held", {24'd0, sample_out}, 32'h80);
    check("to no valid", sv_cnt - sv0, 32'd0);
    step(1);
    cfg_pause = 1'b0;
    wait_pulse(0, "to next start");
    check("to next eval_t", {8'd0, eval_t}, 32'd1);

    // Async reset mid-WAIT, then a stray done after release
    step(1);
    do_reset();
    wait_pulse(0, "ar start");
    step(2);
    rst_n = 1'b0;
    #1;
    check("ar busy", {31'd0, busy}, 32'd0);
    check("ar eval_t", {8'd0, eval_t}, 32'd0);
    check("ar fault", {30'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sv0 = sv_cnt;
    step(1);
    stray_req++;
    step(4);
    check("ar stray no valid", sv_cnt - sv0, 32'd0);
    check("ar stray sample", {24'd0, sample_out}, 32'h80);
    check("ar stray busy", {31'd0, busy}, 32'd0);
    wait_pulse(0, "ar next start");
    check("ar next eval_t", {8'd0, eval_t}, 32'd0);

    // Time counter wrap and pause on the 4-bit instance
    rst_w_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_pulse(2, $sformatf("w%0d start", i));
      check($sformatf("w%0d eval_t", i), {28'd0, w_eval_t}, i);
    end
    step(1);
    w_pause = 1'b1;
    begin
      int n = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (w_start) n++;
      end
      check("w paused starts", n, 32'd0);
    end
    check("w sample t=15", {24'd0, w_sample_out}, 32'h55);
    check("w fault", {30'd0, w_fault}, 32'd0);
    step(1);
    w_pause = 1'b0;
    wait_pulse(2, "w resume");
    check("w wrapped eval_t", {28'd0, w_eval_t}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bytebeat_sequencer.md
Name: bytebeat_sequencer

Overview:
- Schedules the bytebeat formula evaluator at the audio sample rate.
- Divides the system clock into sample ticks and keeps the time counter t.
- Launches one evaluation per tick with a start/done handshake, then registers the returned sample for the PWM/DAC output stage.
- Top-level glue maps ui_in/uio_in onto its configuration inputs.

Parameters:
- CLK_DIV, 1250: system clocks per sample tick (10 MHz / 8 kHz); legal range ≥ 4.
- T_WIDTH, 24: width of time counter t.
- EVAL_TIMEOUT, 64: max cycles to wait for eval_done after eval_start.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; low freezes divider, t and FSM (no state change)
- cfg_sel  in  2  formula select, sampled only when an evaluation launches
- cfg_pause  in  1  level; high = ticks ignored, divider keeps counting
- cfg_restart  in  1  pulse; forces t to 0 and clears fault flags
- eval_start  out  1  one-cycle launch pulse to evaluator
- eval_t  out  T_WIDTH  t operand, stable from eval_start until done/timeout
- eval_sel  out  2  formula operand, stable as eval_t
- eval_done  in  1  evaluator completion strobe
- eval_sample  in  8  evaluator result, valid with eval_done
- sample_out  out  8  current audio sample
- sample_valid  out  1  one-cycle pulse when sample_out updates
- busy  out  1  high while FSM is in WAIT
- fault  out  2  sticky: [0] overrun, [1] timeout

Behaviour:
- Reset (async assert, sync release): divider=0, t=0, state IDLE, eval_start=0, eval_t=0, eval_sel=0, sample_out=8'h80, sample_valid=0, busy=0, fault=0.
- Divider counts 0..CLK_DIV-1 and wraps when ena=1. tick = (div==CLK_DIV-1) & ena.
- FSM states: IDLE, WAIT.
- IDLE, on tick & !cfg_pause:
  - Next cycle: eval_start=1 for exactly one cycle; eval_t=t; eval_sel=cfg_sel; state WAIT; busy=1; wait counter=0.
  - Latency from tick to eval_start is 1 cycle.
- WAIT:
  - eval_done is ignored in the cycle eval_start is high, and at all times outside WAIT.
  - On eval_done: next cycle sample_out=eval_sample, sample_valid=1 for one cycle, t=t+1 (wraps 2^T_WIDTH-1 to 0), state IDLE, busy=0.
- Timeout: if the wait counter reaches EVAL_TIMEOUT with no done, then next cycle:
  - fault[1]=1, sample_out held, no sample_valid, t=t+1, state IDLE.
- Overrun: a tick while in WAIT (including the same cycle as eval_done) sets fault[0] and is dropped; no queuing.
- cfg_restart:
  - In IDLE: t=0 next cycle.
  - In WAIT: the current evaluation completes or times out normally, but t is loaded with 0 instead of incremented (restart beats increment).
  - Clears fault in all states. If restart coincides with a fault-setting event, the fault set wins.
- cfg_pause: only blocks new launches; an in-flight evaluation finishes normally.
- cfg_sel changes mid-evaluation do not affect eval_sel until the next launch.
- ena=0: all registers hold, including the wait counter. Outputs hold, except that sample_valid and eval_start are forced to 0.
- Async reset mid-WAIT aborts immediately; a late eval_done after reset is ignored because state is IDLE.

Test Plan:
- CLK_DIV=8, EVAL_TIMEOUT=16, evaluator returns t[7:0]^8'h5A after 3 cycles.
  - Run 4 ticks -> eval_start every 8 cycles; eval_t=0,1,2,3; sample_out=5A,5B,58,59; one sample_valid per tick; fault=0.
- Evaluator never responds -> 16 cycles after eval_start: fault=2'b10, sample_out stays 8'h80, t=1, next tick launches eval_t=1.
- Evaluator latency 12 cycles (>CLK_DIV) -> fault[0]=1, every other tick launches, eval_t still sequential 0,1,2.
- Pulse cfg_restart during WAIT with t=5 -> sample posted, t=0, next eval_t=0, fault cleared; cfg_sel changed mid-WAIT appears only at the next launch.
- Preload t=2^24-1 -> after done, t wraps to 0; cfg_pause=1 for 3 ticks -> no eval_start; release -> resumes at t=0.
- Assert rst_n=0 mid-WAIT, then a stray eval_done after release -> all outputs at reset values, no sample_valid.
